// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to compile in the divide datapath; otherwise divide ops complete as illegal.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd,
    output logic [31:0] result,
    output logic        reg_write,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [2:0]  op_q;
    logic [4:0]  rd_lat_q;
    logic        neg_q;
    logic [31:0] opnd_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
`ifdef MULDIV_DIV_EN
    logic        rem_neg_q;
`endif

    logic        a_signed, b_signed;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [31:0] load_opnd, load_lo;
    logic [32:0] mul_sum;
    logic [31:0] step_hi, step_lo;
    logic [63:0] product, product_c;
    logic [31:0] mul_res;
    logic [31:0] final_result;
    logic        illegal_op;
`ifdef MULDIV_DIV_EN
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [31:0] quo_res, rem_res;
`endif

    // Operand magnitudes and signs, decided by the op's signedness at acceptance
    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_a   = a_signed & rs1_val[31];
        sign_b   = b_signed & rs2_val[31];
        mag_a    = sign_a ? (~rs1_val + 32'd1) : rs1_val;
        mag_b    = sign_b ? (~rs2_val + 32'd1) : rs2_val;
`ifdef MULDIV_DIV_EN
        load_opnd = funct3[2] ? mag_b : mag_a;
        load_lo   = funct3[2] ? mag_a : mag_b;
`else
        load_opnd = mag_a;
        load_lo   = mag_b;
`endif
    end

    // One radix-2 step: multiply shifts {hi,lo} right; divide shifts the remainder left
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], lo_q[31:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {hi_q, lo_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        if (op_q[2]) begin
            step_hi = div_diff[33] ? div_shift[31:0] : div_diff[31:0];
            step_lo = {lo_q[30:0], ~div_diff[33]};
        end
`endif
    end

    always_comb begin
        product   = {step_hi, step_lo};
        product_c = neg_q ? (~product + 64'd1) : product;
        mul_res   = (op_q[1:0] == 2'b00) ? product_c[31:0] : product_c[63:32];
`ifdef MULDIV_DIV_EN
        // A zero divisor yields all-ones quotient; the remainder naturally equals the dividend
        quo_res      = (opnd_q == 32'd0) ? 32'hFFFF_FFFF :
                       (neg_q ? (~step_lo + 32'd1) : step_lo);
        rem_res      = rem_neg_q ? (~step_hi + 32'd1) : step_hi;
        final_result = op_q[2] ? (op_q[1] ? rem_res : quo_res) : mul_res;
        illegal_op   = 1'b0;
`else
        final_result = op_q[2] ? 32'd0 : mul_res;
        illegal_op   = op_q[2];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        reg_write  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (count == 5'd31)
                    state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                illegal    = illegal_op;
                reg_write  = (rd != 5'd0) && !illegal_op;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load on acceptance, iterate in CALC, publish result/rd on the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 5'd0;
            op_q      <= 3'd0;
            rd_lat_q  <= 5'd0;
            neg_q     <= 1'b0;
            opnd_q    <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            result    <= 32'd0;
            rd        <= 5'd0;
`ifdef MULDIV_DIV_EN
            rem_neg_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count     <= 5'd0;
                        op_q      <= funct3;
                        rd_lat_q  <= rd_in;
                        neg_q     <= sign_a ^ sign_b;
                        opnd_q    <= load_opnd;
                        hi_q      <= 32'd0;
                        lo_q      <= load_lo;
`ifdef MULDIV_DIV_EN
                        rem_neg_q <= sign_a;
`endif
                    end
                end
                CALC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        result <= final_result;
                        rd     <= rd_lat_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops
// against an arithmetic reference model; adapts to the MULDIV_DIV_EN build.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        reg_write;
    logic        illegal;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    mul_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .rd        (rd),
        .result    (result),
        .reg_write (reg_write),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model from RV32M arithmetic rules
    function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        refResult = 32'd0;
        case (f)
            3'b000: begin p = ua * ub; refResult = p[31:0]; end
            3'b001: begin p = sa * sb; refResult = p[63:32]; end
            3'b010: begin p = sa * ub; refResult = p[63:32]; end
            3'b011: begin p = ua * ub; refResult = p[63:32]; end
            3'b100: begin
                if (b == 0) refResult = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) refResult = 32'h8000_0000;
                else refResult = ia / ib;
            end
            3'b101: refResult = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) refResult = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) refResult = 32'd0;
                else refResult = ia % ib;
            end
            default: refResult = (b == 0) ? a : a % b;
        endcase
        if (f[2] && !DIV_ON)
            refResult = 32'd0;
    endfunction

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] r);
        @(negedge clk);
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = r;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] f, input logic [4:0] r,
                               input logic [31:0] exp);
        int lat;
        logic exp_ill;
        exp_ill = f[2] && !DIV_ON;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, 32);
        check({tag, " result"}, result, exp);
        check({tag, " rd"}, {27'd0, rd}, {27'd0, r});
        check({tag, " reg_write"}, {31'd0, reg_write}, {31'd0, (r != 0) && !exp_ill});
        check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        @(posedge clk);
        #1;
        check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, " done_after"}, {31'd0, done}, 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
        applyStimulus(f, a, b, r);
        check({tag, " busy_accept"}, {31'd0, busy}, 32'd1);
        checkOutput(tag, f, r, exp);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        int first;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  r;

        rst     = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        rd_in   = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset reg_write", {31'd0, reg_write}, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd", {27'd0, rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        runOp("mul_7xm3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        runOp("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
        runOp("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
        runOp("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
        runOp("mul_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);

        runOp("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, DIV_ON ? 32'hFFFF_FFFD : 32'd0);
        runOp("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, DIV_ON ? 32'hFFFF_FFFF : 32'd0);
        runOp("divu_5_0", 3'b101, 32'd5, 32'd0, 5'd8, DIV_ON ? 32'hFFFF_FFFF : 32'd0);
        runOp("remu_5_0", 3'b111, 32'd5, 32'd0, 5'd9, DIV_ON ? 32'd5 : 32'd0);
        runOp("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, DIV_ON ? 32'h8000_0000 : 32'd0);
        runOp("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0);
        runOp("divu_9_3", 3'b101, 32'd9, 32'd3, 5'd12, DIV_ON ? 32'd3 : 32'd0);
        runOp("mul_rd0", 3'b000, 32'd5, 32'd5, 5'd0, 32'd25);

        // Second start mid-operation must be ignored
        applyStimulus(3'b000, 32'd6, 32'd7, 5'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        funct3  = 3'b011;
        rs1_val = 32'd100;
        rs2_val = 32'd100;
        rd_in   = 5'd20;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        first = 0;
        for (int i = 12; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (first == 0) first = i;
            end
        end
        check("ignore_start first_done", first, 32);
        check("ignore_start done_count", dones, 1);
        check("ignore_start result", result, 32'd42);
        check("ignore_start rd", {27'd0, rd}, 32'd9);

        // Asynchronous reset in the middle of CALC
        applyStimulus(3'b000, 32'd123, 32'd456, 5'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort rd", {27'd0, rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || reg_write) dones++;
        end
        check("abort no_done", dones, 0);
        runOp("mul_3x4", 3'b000, 32'd3, 32'd4, 5'd3, 32'd12);

        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom_range(0, 7));
            a = pickOperand();
            b = pickOperand();
            r = 5'($urandom_range(0, 31));
            runOp($sformatf("rand%0d_f%0d", n, f), f, a, b, r, refResult(f, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have the following ports, one per line:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  32  operand A (register-file data1).
- rs2_val  in  32  operand B (register-file data2).
- rd_in  in  5  destination register index.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- rd  out  5  latched destination index; drives register-file rd.
- result  out  32  registered result; drives register-file write_data.
- reg_write  out  1  equals done AND (rd != 0); drives register-file reg_write.
- illegal  out  1  one-cycle pulse with done for an unsupported op.

Function
REQ-002 SHALL implement the states IDLE, CALC and DONE.
REQ-003 IDLE with start=1: SHALL latch funct3, rs1_val, rs2_val and rd_in, clear the iteration counter, and enter CALC at that edge.
REQ-004 start SHALL be ignored in CALC and DONE; there is no queueing.
REQ-005 CALC SHALL run a radix-2 iterative algorithm with exactly 32 iterations, one per rising edge, using counter values 0..31.
REQ-006 When the counter reaches 31, the next edge SHALL enter DONE; done SHALL be high for exactly the one cycle following the 32nd rising edge after the accepting edge.
REQ-007 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-008 Latency SHALL be fixed for every op and operand value, including the special cases.
REQ-009 Multiply SHALL use shift-add on operand magnitudes followed by sign correction to a 64-bit product, with operand signedness as follows:
- MUL: low 32 bits.
- MULH: high 32 bits, signed x signed.
- MULHSU: high 32 bits, signed x unsigned.
- MULHU: high 32 bits, unsigned x unsigned.
REQ-010 Divide SHALL use restoring division on magnitudes. The quotient sign is the XOR of the operand signs; the remainder sign follows the dividend. Truncation is toward zero.
REQ-011 Divide by zero SHALL give quotient 0xFFFFFFFF for DIV and DIVU, and remainder equal to rs1_val for REM and REMU.
REQ-012 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0.
REQ-013 result and rd SHALL update only on entry to DONE and hold their values until the next entry to DONE.
REQ-014 reg_write SHALL be 0 when rd = 0, even while done = 1.

Reset
REQ-015 rst SHALL asynchronously force: state IDLE, busy 0, done 0, reg_write 0, illegal 0, result 0x00000000, rd 0, and all internal datapath registers 0.
REQ-016 rst asserted mid-CALC or in DONE SHALL abort the operation with no done or reg_write pulse; the first start after deassertion SHALL be accepted normally.

Configuration
REQ-017 Macro MULDIV_DIV_EN SHALL control whether the divide datapath is compiled in.
REQ-018 With MULDIV_DIV_EN defined: all eight ops SHALL be supported and illegal SHALL be tied to 0.
REQ-019 Without MULDIV_DIV_EN: no divide logic SHALL be synthesized. Ops with funct3[2]=1 SHALL complete with the same latency, with result 0, illegal=1 during the done cycle, and reg_write=0. Multiply behaviour SHALL be unchanged.

Verification
REQ-020 MUL 7 x 0xFFFFFFFD, rd=5 -> result 0xFFFFFFEB; done and reg_write high exactly in the cycle after the 32nd edge following acceptance; busy low afterward.
REQ-021 0xFFFFFFFF x 0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF; MUL 0x00000001.
REQ-022 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-023 Second start pulsed at CALC counter 10 -> ignored, exactly one done; an op with rd=0 -> done=1, reg_write=0.
REQ-024 rst pulsed at CALC counter 10 -> busy, done, result and rd are 0 immediately; no done follows; a new MUL 3x4 afterward -> 12 with nominal latency.
REQ-025 Build without MULDIV_DIV_EN, op DIVU 9/3 -> result 0, illegal=1 and done=1 in the same cycle, reg_write=0.
